// File: rtl/and2_sched_pkg.sv
// Shared defaults and helpers for the round-robin AND scheduler.
package and2_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward (mod N) and owns the rotating pointer.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en_adv,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_gnt
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  logic [IDW-1:0] idx;
  int unsigned    j;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      idx = IDW'(j);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    any_gnt = en_adv && found;
    gnt     = '0;
    ptr_d   = ptr_q;
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/and2_rr_sched.sv
// Shares one registered 2-input AND (operand stage S1, result stage S2) among
// N_REQ requesters with round-robin grants, output backpressure and a grant enable.
module and2_rr_sched
  import and2_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  parameter  int unsigned W     = W_DEF,
  localparam int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               rsp_ready,
  output logic               idle
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
  } s1_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic [W-1:0]    c;
  } s2_t;

  function automatic logic [W-1:0] and_bits(input logic [W-1:0] a, input logic [W-1:0] b);
    return a & b;
  endfunction

  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic             adv1, adv2, any_gnt, grant_en;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [W-1:0]     mux_a, mux_b;

  assign adv2     = !s2_q.v || rsp_ready;
  assign adv1     = !s1_q.v || adv2;
  assign grant_en = en && adv1 && !rst;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en_adv  (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // one-hot grant selects the operands with an AND-OR mux
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      mux_a = mux_a | (req_a[i*W +: W] & {W{gnt[i]}});
      mux_b = mux_b | (req_b[i*W +: W] & {W{gnt[i]}});
    end
  end

  // S0 -> S1: capture granted pair; S1 -> S2: compute and register the result
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (adv1) begin
      s1_d.v  = any_gnt;
      s1_d.id = gnt_idx;
      s1_d.a  = mux_a;
      s1_d.b  = mux_b;
    end
    if (adv2) begin
      s2_d.v  = s1_q.v;
      s2_d.id = s1_q.id;
      s2_d.c  = and_bits(s1_q.a, s1_q.b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q.v <= 1'b0;
      s2_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = s2_q.v;
  assign rsp_data  = s2_q.c;
  assign rsp_id    = s2_q.id;
  assign idle      = !s1_q.v && !s2_q.v && !any_gnt;

endmodule

// File: tb/tb_and2_rr_sched.sv
// Directed bench for and2_rr_sched with a queue-based reference model checked every cycle.
module tb_and2_rr_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           rsp_ready = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           idle;

  and2_rr_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .idle      (idle)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: FIFO of granted results; head_out marks the head as visible at the output.
  typedef struct {
    int           id;
    logic [W-1:0] d;
  } exp_t;
  exp_t q[$];
  bit   head_out = 1'b0;
  int   m_ptr    = 0;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit can_grant();
    return !rst && en && (q.size() < 2 || rsp_ready) && (req_valid != '0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      head_out = 1'b0;
      m_ptr    = 0;
    end else begin
      bit   g;
      int   w;
      exp_t e;
      g = can_grant();
      w = winner(req_valid, m_ptr);
      if (head_out && rsp_ready) begin
        void'(q.pop_front());
        head_out = 1'b0;
      end
      if (!head_out) head_out = (q.size() > 0);
      if (g) begin
        e.id = w;
        e.d  = req_a[w*W +: W] & req_b[w*W +: W];
        q.push_back(e);
        m_ptr = (w + 1) % N;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic [N-1:0] er;
      er = '0;
      if (can_grant()) er[winner(req_valid, m_ptr)] = 1'b1;
      check("m_req_ready", 32'(req_ready), 32'(er));
      check("m_rsp_valid", 32'(rsp_valid), 32'(head_out));
      if (head_out) begin
        check("m_rsp_data", 32'(rsp_data), 32'(q[0].d));
        check("m_rsp_id", 32'(rsp_id), 32'(q[0].id));
      end
      check("m_idle", 32'(idle), 32'(q.size() == 0 && !can_grant()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'hFF;
      req_b[i*W +: W] = 8'(i + 1);
    end
  endtask

  initial begin
    logic [N-1:0] exp_g;
    bit           fire;
    // requests during reset are never granted
    rst = 1'b1; en = 1'b1; req_valid = 4'hF;
    tick();
    at_neg(); check("rst_ready", 32'(req_ready), 32'h0);
    do_reset();
    chk_on = 1'b1;
    at_neg();
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    tick();

    // single request
    en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0001;
    req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C;
    at_neg(); check("single_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick();
    at_neg();
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data", 32'(rsp_data), 32'h30);
    check("single_id", 32'(rsp_id), 32'h0);
    tick();
    at_neg(); check("single_once", 32'(rsp_valid), 32'h0);
    tick();

    // all four requesting: grants 0,1,2,3,0 back-to-back
    do_reset();
    set_ops(); en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    for (int k = 0; k <= 6; k++) begin
      at_neg();
      if (k < 5) begin
        exp_g = 4'(1 << (k % 4));
        check("rr_grant", 32'(req_ready), 32'(exp_g));
      end
      if (k >= 2) begin
        check("rr_data", 32'(rsp_data), 32'((k - 2) % 4 + 1));
        check("rr_id", 32'(rsp_id), 32'((k - 2) % 4));
      end
      tick();
      if (k == 4) req_valid = '0;
    end
    tick();

    // wrap: ptr at 3 after granting 2, then 3 wins before 0
    do_reset();
    en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0100;
    at_neg(); check("wrap_g2", 32'(req_ready), 32'h4);
    tick(); req_valid = 4'b1001;
    at_neg(); check("wrap_g3", 32'(req_ready), 32'h8);
    tick();
    at_neg(); check("wrap_g0", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick(); tick(); tick();

    // backpressure on a stream from requester 1
    do_reset();
    en = 1'b1; req_a[15:8] = 8'hFF; req_b[15:8] = 8'h01; req_valid = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      rsp_ready = !(c >= 2 && c <= 4);
      at_neg();
      fire = req_ready[1];
      if (c == 2 || c == 4) begin
        check("bp_ready", 32'(req_ready), 32'h0);
        check("bp_data", 32'(rsp_data), 32'h01);
        check("bp_id", 32'(rsp_id), 32'h1);
      end
      if (c == 6) check("bp_next", 32'(rsp_data), 32'h02);
      tick();
      if (fire) req_b[15:8] = req_b[15:8] + 8'h01;
      if (c == 9) req_valid = '0;
    end
    rsp_ready = 1'b1;
    tick(); tick(); tick();

    // en=0 drains two in-flight pairs
    do_reset();
    set_ops(); en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    tick(); tick();
    en = 1'b0;
    at_neg();
    check("en0_ready", 32'(req_ready), 32'h0);
    check("en0_data0", 32'(rsp_data), 32'h01);
    tick();
    at_neg();
    check("en0_data1", 32'(rsp_data), 32'h02);
    check("en0_id1", 32'(rsp_id), 32'h1);
    tick();
    at_neg();
    check("en0_idle", 32'(idle), 32'h1);
    check("en0_valid", 32'(rsp_valid), 32'h0);
    tick(); req_valid = '0;
    tick();

    // reset with both stages full
    do_reset();
    set_ops(); en = 1'b1; rsp_ready = 1'b0; req_valid = 4'hF;
    tick(); tick();
    rst = 1'b1;
    at_neg(); check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    at_neg();
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_data", 32'(rsp_data), 32'h0);
    check("mid_rst_id", 32'(rsp_id), 32'h0);
    check("mid_rst_grant", 32'(req_ready), 32'h1);
    tick(); tick();
    req_valid = '0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
